// File: rtl/control_unit.sv
// Instruction sequencer for the Full Nibble Processor: fetches 24-bit words,
// decodes them and drives register-file / ALU control one instruction at a time.
module control_unit #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [23:0]      imem_data,
  input  logic             imem_ack,
  output logic [4:0]       rf_ra,
  output logic [4:0]       rf_rb,
  output logic [1:0]       alu_op,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic             wr_sel,
  output logic [7:0]       imm,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [23:0]      ir_q;
  logic             hold_q;
  logic             rf_we_q;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;

  logic [2:0]       op;
  logic             is_alu;
  logic             unused_y_hi;

  assign op          = ir_q[23:21];
  assign is_alu      = (op >= 3'b010) && (op <= 3'b101);
  assign unused_y_hi = ^ir_q[7:5];

  // The request is a live function of run so a zero-wait ack completes a fetch
  // in the same cycle; once held it survives run dropping until the ack.
  assign imem_req  = rst_n && (state_q == S_FETCH) && (run || hold_q);
  assign imem_addr = pc_q;

  assign rf_ra   = ir_q[12:8];
  assign rf_rb   = ir_q[4:0];
  assign rf_wa   = ir_q[20:16];
  assign imm     = ir_q[15:8];
  assign alu_op  = is_alu ? 2'(op - 3'b010) : 2'b00;
  assign wr_sel  = is_alu;
  assign rf_we   = rf_we_q;
  assign halted  = halted_q;
  assign retired = retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      hold_q    <= 1'b0;
      rf_we_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_req) begin
            if (imem_ack) begin
              ir_q    <= imem_data;
              pc_q    <= pc_q + PC_W'(1);
              hold_q  <= 1'b0;
              state_q <= S_DECODE;
            end else begin
              hold_q  <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          rf_we_q <= (op == OP_LDI) || is_alu;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          rf_we_q   <= 1'b0;
          retired_q <= retired_q + CNT_W'(1);
          if (op == OP_JMP) begin
            pc_q <= ir_q[8 +: PC_W];
          end
          if (op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q  <= S_FETCH;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each task drives one scenario and checks
// the outputs against hand-computed values.
module tb_control_unit;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic [23:0]      imem_data;
  logic             imem_ack;
  logic [4:0]       rf_ra;
  logic [4:0]       rf_rb;
  logic [1:0]       alu_op;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic             wr_sel;
  logic [7:0]       imm;
  logic             halted;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_ret;

  control_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .alu_op(alu_op), .rf_we(rf_we), .rf_wa(rf_wa),
    .wr_sel(wr_sel), .imm(imm), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction with a same-cycle ack for exactly one edge.
  task automatic fetch_now(input logic [23:0] w);
    imem_data = w;
    imem_ack  = 1'b1;
    step();
    imem_ack  = 1'b0;
    imem_data = 24'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = 24'h0;
    step(); step();
    rst_n = 1'b1;
    #1;
    exp_ret = '0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %0h want 0", imem_addr); end
    checks++; if ({rf_we, halted, wr_sel} !== 3'b000) begin errors++; $display("FAIL reset_flags got %0b want 000", {rf_we, halted, wr_sel}); end
    checks++; if (retired !== 16'h0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    checks++; if ({rf_ra, rf_rb, rf_wa, imm, alu_op} !== 25'h0) begin errors++; $display("FAIL reset_fields got %0h want 0", {rf_ra, rf_rb, rf_wa, imm, alu_op}); end
  endtask

  task automatic test_ldi();
    run = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ldi_req got %0b want 1", imem_req); end
    fetch_now(24'h235A00);
    checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd3) begin errors++; $display("FAIL ldi_decode got we=%0b wa=%0d want we=0 wa=3", rf_we, rf_wa); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || wr_sel !== 1'b0 || imm !== 8'h5A) begin
      errors++; $display("FAIL ldi_exec got we=%0b wa=%0d sel=%0b imm=%0h want we=1 wa=3 sel=0 imm=5a", rf_we, rf_wa, wr_sel, imm);
    end
    step();
    exp_ret++;
    checks++; if (imem_addr !== 8'h01 || retired !== exp_ret || rf_we !== 1'b0) begin
      errors++; $display("FAIL ldi_after got addr=%0h ret=%0d we=%0b want addr=1 ret=%0d we=0", imem_addr, retired, rf_we, exp_ret);
    end
  endtask

  task automatic test_add();
    fetch_now(24'h440102);
    step();
    checks++; if (rf_ra !== 5'd1 || rf_rb !== 5'd2 || alu_op !== 2'b00 || rf_we !== 1'b1 || rf_wa !== 5'd4 || wr_sel !== 1'b1) begin
      errors++; $display("FAIL add_exec got ra=%0d rb=%0d op=%0d we=%0b wa=%0d sel=%0b want 1 2 0 1 4 1", rf_ra, rf_rb, alu_op, rf_we, rf_wa, wr_sel);
    end
    step();
    exp_ret++;
    checks++; if (imem_addr !== 8'h02 || retired !== exp_ret) begin errors++; $display("FAIL add_after got addr=%0h ret=%0d want addr=2 ret=%0d", imem_addr, retired, exp_ret); end
  endtask

  task automatic test_alu_ops();
    logic [23:0] words [3] = '{24'h610506, 24'h820708, 24'hA00304};
    logic [1:0]  ops   [3] = '{2'b01, 2'b10, 2'b11};
    logic [4:0]  was   [3] = '{5'd1, 5'd2, 5'd0};
    for (int i = 0; i < 3; i++) begin
      fetch_now(words[i]);
      step();
      checks++; if (alu_op !== ops[i] || rf_we !== 1'b1 || wr_sel !== 1'b1 || rf_wa !== was[i]) begin
        errors++; $display("FAIL alu_op%0d got op=%0d we=%0b sel=%0b wa=%0d want op=%0d we=1 sel=1 wa=%0d", i, alu_op, rf_we, wr_sel, rf_wa, ops[i], was[i]);
      end
      step();
      exp_ret++;
    end
    checks++; if (imem_addr !== 8'h05 || retired !== exp_ret) begin errors++; $display("FAIL alu_after got addr=%0h ret=%0d want addr=5 ret=%0d", imem_addr, retired, exp_ret); end
  endtask

  task automatic test_jmp();
    fetch_now(24'hC01000);
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL jmp_we got %0b want 0", rf_we); end
    step();
    exp_ret++;
    checks++; if (imem_addr !== 8'h10 || retired !== exp_ret) begin errors++; $display("FAIL jmp_target got addr=%0h ret=%0d want addr=10 ret=%0d", imem_addr, retired, exp_ret); end
  endtask

  task automatic test_wait();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) run = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin
        errors++; $display("FAIL wait%0d got req=%0b addr=%0h want req=1 addr=10", i, imem_req, imem_addr);
      end
      step();
    end
    imem_data = 24'h000000;
    imem_ack  = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_ackcycle got req=%0b want 1", imem_req); end
    step();
    imem_ack = 1'b0;
    step(); step();
    exp_ret++;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h11 || retired !== exp_ret) begin
      errors++; $display("FAIL wait_done got req=%0b addr=%0h ret=%0d want req=0 addr=11 ret=%0d", imem_req, imem_addr, retired, exp_ret);
    end
    step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h11) begin errors++; $display("FAIL wait_paused got req=%0b addr=%0h want req=0 addr=11", imem_req, imem_addr); end
  endtask

  task automatic test_halt();
    run = 1'b1;
    fetch_now(24'hE00000);
    step(); step();
    exp_ret++;
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL halt_retired got %0d want %0d", retired, exp_ret); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || rf_we !== 1'b0) begin
        errors++; $display("FAIL halt_hold%0d got halted=%0b req=%0b we=%0b want 1 0 0", i, halted, imem_req, rf_we);
      end
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    exp_ret = '0;
    checks++; if (imem_addr !== 8'h00 || halted !== 1'b0 || retired !== 16'h0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL halt_reset got addr=%0h halted=%0b ret=%0d req=%0b want 0 0 0 1", imem_addr, halted, retired, imem_req);
    end
    fetch_now(24'h000000);
    step(); step();
    exp_ret++;
    checks++; if (imem_addr !== 8'h01 || retired !== exp_ret) begin errors++; $display("FAIL halt_refetch got addr=%0h ret=%0d want addr=1 ret=%0d", imem_addr, retired, exp_ret); end
  endtask

  task automatic test_wrap_and_reset();
    fetch_now(24'hC0FF00);
    step(); step();
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_jmp got addr=%0h want ff", imem_addr); end
    fetch_now(24'h000000);
    step(); step();
    exp_ret += 2;
    checks++; if (imem_addr !== 8'h00 || retired !== exp_ret) begin errors++; $display("FAIL wrap_pc got addr=%0h ret=%0d want addr=0 ret=%0d", imem_addr, retired, exp_ret); end
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_waitreq got %0b want 1", imem_req); end
    rst_n = 1'b0;
    run   = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h00 || retired !== 16'h0) begin
      errors++; $display("FAIL reset_in_wait got req=%0b addr=%0h ret=%0d want 0 0 0", imem_req, imem_addr, retired);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_alu_ops();
    test_jmp();
    test_wait();
    test_halt();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
